// File: rtl/tqvp_uart_rx_fifo_if.sv
// Purpose: bundles the deserialiser handshake, bus strobes and status of the UART RX FIFO.
// Latency: wires only, no storage.
// Backpressure: rx_read is the sink-ready returned to the deserialiser.
interface tqvp_uart_rx_fifo_if #(
  parameter int DEPTH_LOG2 = 3,
  parameter int TMO_W      = 16
);
  logic                  rx_valid;
  logic [7:0]            rx_data;
  logic                  rx_read;
  logic                  pop;
  logic                  flush;
  logic [DEPTH_LOG2:0]   thresh;
  logic [TMO_W-1:0]      tmo_cycles;
  logic                  clr_overrun;
  logic [7:0]            rd_data;
  logic [DEPTH_LOG2:0]   level;
  logic                  empty;
  logic                  full;
  logic                  overrun;
  logic                  rts_hold;
  logic                  irq;

  // Deserialiser/bus side: drives bytes and strobes, observes status.
  modport master (
    output rx_valid, rx_data, pop, flush, thresh, tmo_cycles, clr_overrun,
    input  rx_read, rd_data, level, empty, full, overrun, rts_hold, irq
  );

  // FIFO side.
  modport slave (
    input  rx_valid, rx_data, pop, flush, thresh, tmo_cycles, clr_overrun,
    output rx_read, rd_data, level, empty, full, overrun, rts_hold, irq
  );
endinterface

// File: rtl/tqvp_uart_rx_fifo.sv
// Purpose: receive byte FIFO with threshold/idle-timeout interrupt, overrun flag and RTS hold.
// Latency: a pushed byte is visible on rd_data/level one cycle after the push edge.
// Backpressure: rx_read = !full; a byte offered while full is dropped and sets overrun.
module tqvp_uart_rx_fifo #(
  parameter int DEPTH_LOG2 = 3,
  parameter int TMO_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  tqvp_uart_rx_fifo_if.slave   bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] LVL_FULL = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] LVL_HOLD = (DEPTH_LOG2+1)'(DEPTH - 2);

  logic [7:0]            mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr_q, wptr_d;
  logic [DEPTH_LOG2-1:0] rptr_q, rptr_d;
  logic [DEPTH_LOG2:0]   level_q, level_d;
  logic                  overrun_q, overrun_d;
  logic [TMO_W-1:0]      tmo_cnt_q, tmo_cnt_d;
  logic                  tmo_flag_q, tmo_flag_d;

  logic empty, full, push, pop_ok;

  assign empty  = (level_q == '0);
  assign full   = (level_q == LVL_FULL);
  assign push   = bus.rx_valid && !full;
  // A pop on an empty FIFO is ignored, so an empty-cycle push+pop only pushes.
  assign pop_ok = bus.pop && !empty;

  // Next-state: pointer/level/timeout update, with flush overriding push and pop.
  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    level_d    = level_q;
    tmo_cnt_d  = tmo_cnt_q;
    tmo_flag_d = tmo_flag_q;
    overrun_d  = overrun_q;

    if (push)   wptr_d = wptr_q + 1'b1;
    if (pop_ok) rptr_d = rptr_q + 1'b1;
    case ({push, pop_ok})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase

    // Idle counter only runs while data sits unread; saturates at the timeout.
    if (push || pop_ok || empty)       tmo_cnt_d = '0;
    else if (tmo_cnt_q < bus.tmo_cycles) tmo_cnt_d = tmo_cnt_q + 1'b1;

    if (push || pop_ok)
      tmo_flag_d = 1'b0;
    else if ((tmo_cnt_q == bus.tmo_cycles) && (bus.tmo_cycles != '0) && !empty)
      tmo_flag_d = 1'b1;

    if (bus.flush) begin
      wptr_d     = '0;
      rptr_d     = '0;
      level_d    = '0;
      tmo_cnt_d  = '0;
      tmo_flag_d = 1'b0;
    end

    // A new overrun event beats any clear arriving in the same cycle.
    if (bus.rx_valid && full)               overrun_d = 1'b1;
    else if (bus.clr_overrun || bus.flush)  overrun_d = 1'b0;
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      level_q    <= '0;
      overrun_q  <= 1'b0;
      tmo_cnt_q  <= '0;
      tmo_flag_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      level_q    <= level_d;
      overrun_q  <= overrun_d;
      tmo_cnt_q  <= tmo_cnt_d;
      tmo_flag_q <= tmo_flag_d;
    end
  end

  // Byte storage; contents are don't-care until written, rd_data masks when empty.
  always_ff @(posedge clk) begin
    if (push && !bus.flush) mem_q[wptr_q] <= bus.rx_data;
  end

  assign bus.rx_read  = !full;
  assign bus.rd_data  = empty ? 8'h00 : mem_q[rptr_q];
  assign bus.level    = level_q;
  assign bus.empty    = empty;
  assign bus.full     = full;
  assign bus.overrun  = overrun_q;
  assign bus.rts_hold = (level_q >= LVL_HOLD);
  assign bus.irq      = ((bus.thresh != '0) && (level_q >= bus.thresh)) || tmo_flag_q;
endmodule

// File: tb/tb_tqvp_uart_rx_fifo.sv
// Purpose: directed bench for tqvp_uart_rx_fifo with a byte scoreboard checked on every pop.
// Latency: inputs driven 1ns after the rising edge, pop data sampled on the falling edge.
// Backpressure: exercises full/rx_read, overrun, rts_hold, flush and async reset.
module tb_tqvp_uart_rx_fifo;
  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  logic [7:0] exp_q [$];

  tqvp_uart_rx_fifo_if #(.DEPTH_LOG2(3), .TMO_W(16)) bus ();

  tqvp_uart_rx_fifo #(.DEPTH_LOG2(3), .TMO_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: whenever the DUT accepts a pop, its head byte must match the oldest expected byte.
  always @(negedge clk) begin
    if (rst_n && bus.pop && !bus.empty) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_unexpected: got 0x%0h, expected no data", bus.rd_data);
      end else begin
        check("pop_data", {24'h0, bus.rd_data}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_b(input logic [7:0] b);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    exp_q.push_back(b);
    cyc();
    bus.rx_valid = 1'b0;
  endtask

  task automatic pop_b();
    bus.pop = 1'b1;
    cyc();
    bus.pop = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_empty"},   {31'h0, bus.empty},    32'd1);
    check({tag, "_full"},    {31'h0, bus.full},     32'd0);
    check({tag, "_rx_read"}, {31'h0, bus.rx_read},  32'd1);
    check({tag, "_rd_data"}, {24'h0, bus.rd_data},  32'h0);
    check({tag, "_irq"},     {31'h0, bus.irq},      32'd0);
    check({tag, "_rts"},     {31'h0, bus.rts_hold}, 32'd0);
    check({tag, "_level"},   {28'h0, bus.level},    32'd0);
    check({tag, "_overrun"}, {31'h0, bus.overrun},  32'd0);
  endtask

  initial begin
    int lvl;
    logic do_pop;

    rst_n           = 1'b0;
    bus.rx_valid    = 1'b0;
    bus.rx_data     = 8'h00;
    bus.pop         = 1'b0;
    bus.flush       = 1'b0;
    bus.thresh      = '0;
    bus.tmo_cycles  = '0;
    bus.clr_overrun = 1'b0;
    #3;
    check_reset_outputs("reset");
    cyc();
    rst_n = 1'b1;
    cyc();

    // Basic push/pop ordering.
    push_b(8'h41);
    push_b(8'h42);
    push_b(8'h43);
    check("basic_level", {28'h0, bus.level}, 32'd3);
    check("basic_head", {24'h0, bus.rd_data}, 32'h41);
    pop_b();
    pop_b();
    pop_b();
    check("basic_empty", {31'h0, bus.empty}, 32'd1);
    check("basic_rd_zero", {24'h0, bus.rd_data}, 32'h0);

    // Pop while empty is ignored.
    pop_b();
    check("empty_pop_level", {28'h0, bus.level}, 32'd0);

    // Fill to full, watch rts_hold, then overrun and its clear.
    for (int i = 0; i < 8; i++) begin
      push_b(8'h10 + 8'(i));
      check("fill_rts", {31'h0, bus.rts_hold}, (i + 1 >= 6) ? 32'd1 : 32'd0);
    end
    check("fill_full", {31'h0, bus.full}, 32'd1);
    check("fill_rx_read", {31'h0, bus.rx_read}, 32'd0);
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'hEE;
    cyc();
    bus.rx_valid = 1'b0;
    check("overrun_set", {31'h0, bus.overrun}, 32'd1);
    check("overrun_level", {28'h0, bus.level}, 32'd8);
    bus.clr_overrun = 1'b1;
    cyc();
    bus.clr_overrun = 1'b0;
    check("overrun_clr", {31'h0, bus.overrun}, 32'd0);
    for (int i = 0; i < 8; i++) pop_b();
    check("drain_empty", {31'h0, bus.empty}, 32'd1);

    // Interleaved traffic across the pointer wrap.
    lvl = 0;
    for (int i = 0; i < 12; i++) begin
      do_pop       = (i % 3 != 0) && (lvl > 0);
      bus.rx_valid = 1'b1;
      bus.rx_data  = 8'h60 + 8'(i);
      exp_q.push_back(8'h60 + 8'(i));
      bus.pop      = do_pop;
      cyc();
      lvl = lvl + 1 - (do_pop ? 1 : 0);
      check("wrap_level", {28'h0, bus.level}, 32'(lvl));
    end
    bus.rx_valid = 1'b0;
    bus.pop      = 1'b0;
    for (int i = 0; i < lvl; i++) pop_b();
    check("wrap_empty", {31'h0, bus.empty}, 32'd1);

    // Threshold interrupt.
    bus.thresh = 4'd4;
    for (int i = 0; i < 3; i++) begin
      push_b(8'h71 + 8'(i));
      check("thr_irq_low", {31'h0, bus.irq}, 32'd0);
    end
    push_b(8'h74);
    check("thr_irq_high", {31'h0, bus.irq}, 32'd1);
    pop_b();
    check("thr_irq_pop", {31'h0, bus.irq}, 32'd0);
    for (int i = 0; i < 3; i++) pop_b();
    bus.thresh = '0;

    // Idle timeout interrupt: fires 11 cycles after the push edge with tmo_cycles=10.
    bus.tmo_cycles = 16'd10;
    push_b(8'h88);
    check("tmo_irq_push", {31'h0, bus.irq}, 32'd0);
    for (int k = 1; k <= 11; k++) begin
      cyc();
      check("tmo_irq_idle", {31'h0, bus.irq}, (k == 11) ? 32'd1 : 32'd0);
    end
    pop_b();
    check("tmo_irq_pop", {31'h0, bus.irq}, 32'd0);
    bus.tmo_cycles = '0;

    // Flush beats a simultaneous push.
    for (int i = 0; i < 5; i++) push_b(8'h90 + 8'(i));
    check("flush_pre_level", {28'h0, bus.level}, 32'd5);
    bus.flush    = 1'b1;
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'hAA;
    cyc();
    bus.flush    = 1'b0;
    bus.rx_valid = 1'b0;
    exp_q.delete();
    check("flush_level", {28'h0, bus.level}, 32'd0);
    check("flush_empty", {31'h0, bus.empty}, 32'd1);
    check("flush_overrun", {31'h0, bus.overrun}, 32'd0);
    check("flush_rd_data", {24'h0, bus.rd_data}, 32'h0);

    // Asynchronous reset in the middle of a burst.
    bus.thresh   = 4'd1;
    bus.rx_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      bus.rx_data = 8'hB0 + 8'(i);
      cyc();
    end
    bus.rx_valid = 1'b0;
    check("burst_irq", {31'h0, bus.irq}, 32'd1);
    check("burst_rts", {31'h0, bus.rts_hold}, 32'd1);
    bus.thresh = '0;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    cyc();
    rst_n = 1'b1;
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
